cam_axi_wr_target: RTL and testbench
====================================

// Module: cam_axi_wr_target
// PURPOSE
//  AXI4 write-channel responder (AW/W/B only) at the far end of the camera pixel writer.
//  Decodes single-beat writes to two targets:
//    - SPIADR: latches a RAM address word.
//    - TXFIFO: pushes {address, data} into an internal FIFO.
//  The FIFO drains to the SPI/RAM side over a valid/ready stream. Single clock domain.
// PARAMETERS
//  AXI4_ADDRESS_WIDTH  32            AW address width
//  AXI4_WDATA_WIDTH    32            W data width (fixed 32; strobe width = 4)
//  AXI4_ID_WIDTH       16            AW/B ID width
//  AXI4_USER_WIDTH     10            AW/W/B user width
//  TXFIFO              32'h1A102018  address of pixel-data FIFO port
//  SPIADR              32'h0A10200C  address of RAM-address register
//  FIFO_DEPTH          8             entries (power of 2, >=2)
// PORTS
//  iclk           in   1      clock
//  rst            in   1      synchronous reset, active-high
//  aw_id_i        in   ID     write ID
//  aw_addr_i      in   ADDR   write address
//  aw_len_i       in   8      burst length-1
//  aw_valid_i     in   1      AW valid
//  aw_ready_o     out  1      AW ready
//  w_data_i       in   32     write data
//  w_strb_i       in   4      byte strobes
//  w_last_i       in   1      last beat
//  w_valid_i      in   1      W valid
//  w_ready_o      out  1      W ready
//  b_id_o         out  ID     response ID (= captured aw_id)
//  b_resp_o       out  2      00 OKAY, 10 SLVERR, 11 DECERR
//  b_user_o       out  USER   always 0
//  b_valid_o      out  1      B valid
//  b_ready_i      in   1      B ready
//  ram_addr_o     out  32     current SPIADR register value
//  out_addr_o     out  32     FIFO head: address captured at push
//  out_data_o     out  32     FIFO head: pixel word
//  out_valid_o    out  1      FIFO not empty
//  out_ready_i    in   1      pop when out_valid_o & out_ready_i
//  fifo_level_o   out  log2(D)+1  current occupancy
// BEHAVIOUR
//  Reset (rst=1 at iclk edge): FSM->IDLE; aw_ready_o=1, w_ready_o=0, b_valid_o=0,
//  b_resp_o=00, b_id_o=0, ram_addr_o=0, FIFO empty, fifo_level_o=0. Reset mid-transaction
//  aborts it: no B is issued and no push occurs.
//  FSM IDLE -> DATA -> RESP -> IDLE, one transaction outstanding; all outputs registered.
//  IDLE: aw_ready_o=1. On aw_valid_i, capture id/addr/len; decode:
//    - TXFIFO -> kind FIFO
//    - SPIADR -> kind REG
//    - else   -> kind BAD
//    err = (aw_len_i!=0). Next cycle DATA.
//  DATA: w_ready_o=1, except kind FIFO && !err && FIFO full, where w_ready_o=0 until space.
//    Each accepted beat:
//    - kind REG, !err, first beat: ram_addr_o <= w_data_i.
//    - kind FIFO, !err: push {ram_addr_o, w_data_i}.
//    - Beats with err or BAD are accepted and discarded.
//    On accepted beat with w_last_i=1 -> RESP. w_last_i asserted before len+1 beats, or
//    missing at len+1, forces err (continue until w_last_i).
//  RESP: b_valid_o=1 with b_id_o=captured id, b_resp_o = BAD?11 : err?10 : 00.
//    Held stable until b_ready_i; then -> IDLE (aw_ready_o=1 next cycle).
//  Min latency AW handshake -> B valid = 2 cycles (AW@t, W@t+1, B@t+2).
//  FIFO: push and pop in same cycle when full or non-empty both succeed; level unchanged.
//    Pop on empty ignored. Pointers wrap modulo FIFO_DEPTH; level saturates never
//    (full blocks push).
//  REG write followed by FIFO write: pushed entry carries the new ram_addr_o.
// CONFIGURATION
//  `CAMTGT_STRB_CHECK_EN defined:
//    - w_strb_i != 4'hF on any accepted beat sets err: SLVERR, no push,
//      ram_addr_o unchanged.
//    - FIFO-full stall still applies unless err was already set at AW.
//  Undefined: w_strb_i ignored; every beat treated as full-word.
// STRUCTURE
//  Package cam_axi_pkg:
//    - FSM state enum (IDLE/DATA/RESP)
//    - target-kind enum (FIFO/REG/BAD)
//    - resp codes OKAY/SLVERR/DECERR
//    - default TXFIFO/SPIADR addresses
//  Sub-module cam_sync_fifo:
//    - 64-bit x FIFO_DEPTH, single clock, sync active-high reset
//    - push/pop/full/empty/level, first-word-fall-through head
// TESTING
//  1. AW SPIADR len0, W 32'h000007FF strb F, b_ready=1 -> B OKAY id match @t+2; ram_addr_o=7FF.
//  2. SPIADR 7FF then TXFIFO data 32'hA1B2C3D4 -> out_valid_o=1, out_addr_o=7FF,
//     out_data_o=A1B2C3D4, level 1.
//  3. 8 TXFIFO writes, out_ready=0 -> level 8; 9th write stalls w_ready=0;
//     pulse out_ready one cycle -> 9th accepted, level stays 8.
//  4. AW addr 32'h0000_1000 -> data dropped, B resp 11, no push, ram_addr_o unchanged.
//  5. TXFIFO with aw_len=1, two beats, last on 2nd -> SLVERR, no push; with
//     CAMTGT_STRB_CHECK_EN, len0 strb 4'h3 -> SLVERR, no push.
//  6. rst=1 while in RESP with b_ready=0 -> next cycle b_valid=0, aw_ready=1, FIFO empty.

Source files
------------

// File: rtl/cam_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cam_axi_pkg
// Brief    : Shared types and constants for the camera AXI write target:
//            FSM states, target kinds, B response codes, default addresses.
// Revision : 1.0 - initial release
// ============================================================================
package cam_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_FIFO = 2'd0,
    KIND_REG  = 2'd1,
    KIND_BAD  = 2'd2
  } kind_e;

  localparam logic [1:0]  c_resp_okay   = 2'b00;
  localparam logic [1:0]  c_resp_slverr = 2'b10;
  localparam logic [1:0]  c_resp_decerr = 2'b11;

  localparam logic [31:0] c_txfifo_addr = 32'h1A10_2018;
  localparam logic [31:0] c_spiadr_addr = 32'h0A10_200C;

  // Decode errors dominate slave errors.
  function automatic logic [1:0] resp_code(input kind_e kind, input logic err);
    if (kind == KIND_BAD) return c_resp_decerr;
    if (err)              return c_resp_slverr;
    return c_resp_okay;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cam_sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO. A push into a full
//            FIFO succeeds only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cam_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cam_axi_wr_target.sv
`default_nettype none
// ============================================================================
// Module   : cam_axi_wr_target
// Brief    : AXI4 AW/W/B responder. Writes to SPIADR latch the RAM address;
//            writes to TXFIFO push {ram address, pixel word} into a FIFO
//            drained over a valid/ready stream.
//            Optional macro CAMTGT_STRB_CHECK_EN: partial strobes -> SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module cam_axi_wr_target
  import cam_axi_pkg::*;
#(
  parameter int          AXI4_ADDRESS_WIDTH = 32,
  parameter int          AXI4_WDATA_WIDTH   = 32,
  parameter int          AXI4_ID_WIDTH      = 16,
  parameter int          AXI4_USER_WIDTH    = 10,
  parameter logic [31:0] TXFIFO             = c_txfifo_addr,
  parameter logic [31:0] SPIADR             = c_spiadr_addr,
  parameter int          FIFO_DEPTH         = 8
) (
  input  logic                          iclk,
  input  logic                          rst,
  input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]                    aw_len_i,
  input  logic                          aw_valid_i,
  output logic                          aw_ready_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   w_data_i,
  input  logic [3:0]                    w_strb_i,
  input  logic                          w_last_i,
  input  logic                          w_valid_i,
  output logic                          w_ready_o,
  output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
  output logic [1:0]                    b_resp_o,
  output logic [AXI4_USER_WIDTH-1:0]    b_user_o,
  output logic                          b_valid_o,
  input  logic                          b_ready_i,
  output logic [31:0]                   ram_addr_o,
  output logic [31:0]                   out_addr_o,
  output logic [31:0]                   out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  state_e                   r_state;
  state_e                   w_state_nxt;
  kind_e                    r_kind;
  logic                     r_err;
  logic [AXI4_ID_WIDTH-1:0] r_id;
  logic [7:0]               r_len;
  logic [7:0]               r_beat_cnt;
  logic [31:0]              r_ram_addr;

  logic        w_aw_hs;
  logic        w_stall;
  logic        w_w_hs;
  logic        w_last_err;
  logic        w_strb_err;
  logic        w_err_now;
  logic        w_push;
  logic        w_reg_wr;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [63:0] w_fifo_head;

`ifdef CAMTGT_STRB_CHECK_EN
  assign w_strb_err = (w_strb_i != 4'hF);
`else
  // Strobes carry no meaning here; every beat is a full word.
  assign w_strb_err = 1'b0 & (&w_strb_i);
`endif

  // A FIFO-bound clean transfer waits for space; erroneous beats are
  // discarded, so they never need to wait.
  assign w_stall    = (r_kind == KIND_FIFO) && !r_err && w_fifo_full;
  assign aw_ready_o = (r_state == ST_IDLE);
  assign w_ready_o  = (r_state == ST_DATA) && !w_stall;
  assign b_valid_o  = (r_state == ST_RESP);
  assign b_id_o     = r_id;
  assign b_resp_o   = (r_state == ST_RESP) ? resp_code(r_kind, r_err) : c_resp_okay;
  assign b_user_o   = '0;
  assign ram_addr_o = r_ram_addr;

  assign w_aw_hs    = aw_ready_o && aw_valid_i;
  assign w_w_hs     = w_ready_o && w_valid_i;
  // Last flag must land exactly on beat len; early or missing last is an error.
  assign w_last_err = w_last_i ? (r_beat_cnt != r_len) : (r_beat_cnt == r_len);
  assign w_err_now  = r_err || w_last_err || w_strb_err;
  assign w_push     = w_w_hs && (r_kind == KIND_FIFO) && !w_err_now;
  assign w_reg_wr   = w_w_hs && (r_kind == KIND_REG) && !w_err_now && (r_beat_cnt == 8'd0);

  // State register.
  always_ff @(posedge iclk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: one transaction outstanding at a time.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (aw_valid_i)           w_state_nxt = ST_DATA;
      ST_DATA: if (w_w_hs && w_last_i)   w_state_nxt = ST_RESP;
      ST_RESP: if (b_ready_i)            w_state_nxt = ST_IDLE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
  end

  // Transaction capture, error tracking and the RAM address register.
  always_ff @(posedge iclk) begin
    if (rst) begin
      r_kind     <= KIND_BAD;
      r_err      <= 1'b0;
      r_id       <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_ram_addr <= '0;
    end else begin
      if (w_aw_hs) begin
        r_id       <= aw_id_i;
        r_len      <= aw_len_i;
        r_err      <= (aw_len_i != 8'd0);
        r_beat_cnt <= '0;
        if (aw_addr_i == AXI4_ADDRESS_WIDTH'(TXFIFO))      r_kind <= KIND_FIFO;
        else if (aw_addr_i == AXI4_ADDRESS_WIDTH'(SPIADR)) r_kind <= KIND_REG;
        else                                               r_kind <= KIND_BAD;
      end
      if (w_w_hs) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        r_err      <= w_err_now;
      end
      if (w_reg_wr) r_ram_addr <= w_data_i;
    end
  end

  cam_sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (iclk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_ram_addr, w_data_i}),
    .i_pop   (out_ready_i),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level_o)
  );

  assign out_addr_o  = w_fifo_head[63:32];
  assign out_data_o  = w_fifo_head[31:0];
  assign out_valid_o = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_cam_axi_wr_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_axi_wr_target
// Brief    : Self-checking bench for cam_axi_wr_target with a queue-based
//            reference model of the FIFO and the RAM address register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_axi_wr_target;

  localparam logic [31:0] TX  = 32'h1A10_2018;
  localparam logic [31:0] SPI = 32'h0A10_200C;
  localparam int          TMO = 50;

  logic        iclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] aw_id = '0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready_o;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = 4'hF;
  logic        w_last = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready_o;
  logic [15:0] b_id_o;
  logic [1:0]  b_resp_o;
  logic [9:0]  b_user_o;
  logic        b_valid_o;
  logic        b_ready = 1'b0;
  logic [31:0] ram_addr_o;
  logic [31:0] out_addr_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready = 1'b0;
  logic [3:0]  fifo_level_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];
  logic [31:0] m_ram = '0;

  always #5 iclk = ~iclk;

  cam_axi_wr_target dut (
    .iclk (iclk), .rst (rst),
    .aw_id_i (aw_id), .aw_addr_i (aw_addr), .aw_len_i (aw_len),
    .aw_valid_i (aw_valid), .aw_ready_o (aw_ready_o),
    .w_data_i (w_data), .w_strb_i (w_strb), .w_last_i (w_last),
    .w_valid_i (w_valid), .w_ready_o (w_ready_o),
    .b_id_o (b_id_o), .b_resp_o (b_resp_o), .b_user_o (b_user_o),
    .b_valid_o (b_valid_o), .b_ready_i (b_ready),
    .ram_addr_o (ram_addr_o), .out_addr_o (out_addr_o), .out_data_o (out_data_o),
    .out_valid_o (out_valid_o), .out_ready_i (out_ready),
    .fifo_level_o (fifo_level_o)
  );

  // Reference model: applies one whole write transaction to the model state.
  task automatic model_write(input logic [31:0] addr, input logic [7:0] len,
                             input int nbeats, input logic [31:0] d0,
                             input logic [3:0] strb, output logic [1:0] resp);
    bit err;
    err = (len != 0) || (nbeats != int'(len) + 1);
`ifdef CAMTGT_STRB_CHECK_EN
    if (strb != 4'hF) err = 1;
`else
    if (strb == 4'h0) err = err;
`endif
    if (addr != TX && addr != SPI) resp = 2'b11;
    else if (err)                  resp = 2'b10;
    else                           resp = 2'b00;
    if (!err && addr == TX)  q.push_back({m_ram, d0});
    if (!err && addr == SPI) m_ram = d0;
  endtask

  // Bus driver: one AW, nbeats W beats (last on the final one), B after hold cycles.
  task automatic do_write(input logic [31:0] addr, input logic [15:0] id,
                          input logic [7:0] len, input int nbeats,
                          input logic [31:0] d0, input logic [3:0] strb, input int hold,
                          output logic [1:0] resp, output logic [15:0] bid,
                          output int lat, output bit timeout, output bit stable);
    int w;
    resp = 2'b00; bid = '0; lat = 0; timeout = 0; stable = 1;
    @(negedge iclk);
    aw_valid = 1; aw_addr = addr; aw_id = id; aw_len = len;
    w = 0;
    while (!aw_ready_o && w < TMO) begin @(negedge iclk); w++; end
    if (w >= TMO) begin timeout = 1; aw_valid = 0; return; end
    @(negedge iclk); lat++;
    aw_valid = 0;
    for (int b = 0; b < nbeats; b++) begin
      w_valid = 1; w_data = (b == 0) ? d0 : $urandom; w_strb = strb;
      w_last = (b == nbeats - 1);
      w = 0;
      while (!w_ready_o && w < TMO) begin @(negedge iclk); w++; lat++; end
      if (w >= TMO) begin timeout = 1; w_valid = 0; w_last = 0; return; end
      @(negedge iclk); lat++;
    end
    w_valid = 0; w_last = 0;
    w = 0;
    while (!b_valid_o && w < TMO) begin @(negedge iclk); w++; lat++; end
    if (w >= TMO) begin timeout = 1; return; end
    resp = b_resp_o; bid = b_id_o;
    repeat (hold) begin
      @(negedge iclk);
      if (!b_valid_o || b_resp_o !== resp || b_id_o !== bid) stable = 0;
    end
    b_ready = 1;
    @(negedge iclk);
    b_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge iclk);
    checks++;
    if ({aw_ready_o, w_ready_o, b_valid_o, b_resp_o, b_id_o, ram_addr_o, out_valid_o, fifo_level_o}
        !== {1'b1, 1'b0, 1'b0, 2'b00, 16'h0, 32'h0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset: aw_rdy=%b w_rdy=%b b_vld=%b resp=%b id=%h ram=%h ovld=%b lvl=%0d required 1 0 0 00 0 0 0 0",
               aw_ready_o, w_ready_o, b_valid_o, b_resp_o, b_id_o, ram_addr_o, out_valid_o, fifo_level_o);
    end
    rst = 0;
  endtask

  task automatic test_spiadr;
    logic [1:0] r, er; logic [15:0] id; int lat; bit to, st;
    model_write(SPI, 8'd0, 1, 32'h0000_07FF, 4'hF, er);
    do_write(SPI, 16'hBEEF, 8'd0, 1, 32'h0000_07FF, 4'hF, 0, r, id, lat, to, st);
    checks++;
    if (to || r !== er || id !== 16'hBEEF || lat != 2) begin
      errors++;
      $display("FAIL spiadr_b: resp=%b id=%h lat=%0d to=%0d required resp=%b id=beef lat=2 to=0", r, id, lat, to, er);
    end
    checks++;
    if (ram_addr_o !== 32'h7FF) begin
      errors++; $display("FAIL spiadr_ram: got %h required 000007ff", ram_addr_o);
    end
  endtask

  task automatic test_fifo_push;
    logic [1:0] r, er; logic [15:0] id; int lat; bit to, st;
    model_write(TX, 8'd0, 1, 32'hA1B2_C3D4, 4'hF, er);
    do_write(TX, 16'h0042, 8'd0, 1, 32'hA1B2_C3D4, 4'hF, 1, r, id, lat, to, st);
    checks++;
    if (to || r !== 2'b00 || !st) begin
      errors++; $display("FAIL fifo_push_b: resp=%b to=%0d stable=%0d required 00 0 1", r, to, st);
    end
    checks++;
    if (!out_valid_o || out_addr_o !== 32'h7FF || out_data_o !== 32'hA1B2C3D4 || fifo_level_o !== 4'd1) begin
      errors++;
      $display("FAIL fifo_push_head: vld=%b addr=%h data=%h lvl=%0d required 1 000007ff a1b2c3d4 1",
               out_valid_o, out_addr_o, out_data_o, fifo_level_o);
    end
    // Drain the model and the DUT together.
    while (q.size() > 0) begin
      @(negedge iclk);
      checks++;
      if (!out_valid_o || {out_addr_o, out_data_o} !== q[0]) begin
        errors++; $display("FAIL fifo_pop: got %h required %h", {out_addr_o, out_data_o}, q[0]);
      end
      out_ready = 1; @(negedge iclk); out_ready = 0;
      void'(q.pop_front());
    end
  endtask

  task automatic test_fifo_full;
    logic [1:0] r, er; logic [15:0] id; int lat; bit to, st; bit stalled;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model_write(TX, 8'd0, 1, d, 4'hF, er);
      do_write(TX, 16'(i), 8'd0, 1, d, 4'hF, 0, r, id, lat, to, st);
    end
    checks++;
    if (fifo_level_o !== 4'd8) begin
      errors++; $display("FAIL full_level: got %0d required 8", fifo_level_o);
    end
    // Ninth write must stall on W until one entry drains.
    d = $urandom;
    @(negedge iclk); aw_valid = 1; aw_addr = TX; aw_id = 16'h0009; aw_len = 0;
    @(negedge iclk); aw_valid = 0;
    w_valid = 1; w_data = d; w_strb = 4'hF; w_last = 1;
    stalled = 1;
    repeat (3) begin
      if (w_ready_o !== 1'b0 || b_valid_o !== 1'b0) stalled = 0;
      @(negedge iclk);
    end
    checks++;
    if (!stalled) begin
      errors++; $display("FAIL full_stall: w_ready rose while full (w_rdy=%b) required 0", w_ready_o);
    end
    checks++;
    if ({out_addr_o, out_data_o} !== q[0]) begin
      errors++; $display("FAIL full_head: got %h required %h", {out_addr_o, out_data_o}, q[0]);
    end
    out_ready = 1; @(negedge iclk); out_ready = 0;
    void'(q.pop_front());
    @(negedge iclk); w_valid = 0; w_last = 0;
    q.push_back({m_ram, d});
    checks++;
    if (fifo_level_o !== 4'd8 || b_valid_o !== 1'b1 || b_resp_o !== 2'b00 || b_id_o !== 16'h0009) begin
      errors++;
      $display("FAIL full_accept: lvl=%0d b_vld=%b resp=%b id=%h required 8 1 00 0009",
               fifo_level_o, b_valid_o, b_resp_o, b_id_o);
    end
    b_ready = 1; @(negedge iclk); b_ready = 0;
    while (q.size() > 0) begin
      @(negedge iclk);
      checks++;
      if (!out_valid_o || {out_addr_o, out_data_o} !== q[0]) begin
        errors++; $display("FAIL full_drain: got %h required %h", {out_addr_o, out_data_o}, q[0]);
      end
      out_ready = 1; @(negedge iclk); out_ready = 0;
      void'(q.pop_front());
    end
  endtask

  task automatic test_bad_addr;
    logic [1:0] r, er; logic [15:0] id; int lat; bit to, st;
    model_write(32'h0000_1000, 8'd0, 1, 32'hDEAD_BEEF, 4'hF, er);
    do_write(32'h0000_1000, 16'h0777, 8'd0, 1, 32'hDEAD_BEEF, 4'hF, 0, r, id, lat, to, st);
    checks++;
    if (to || r !== 2'b11 || id !== 16'h0777 || fifo_level_o !== 4'd0 || ram_addr_o !== m_ram) begin
      errors++;
      $display("FAIL bad_addr: resp=%b id=%h lvl=%0d ram=%h required 11 0777 0 %h", r, id, fifo_level_o, ram_addr_o, m_ram);
    end
  endtask

  task automatic test_len_err;
    logic [1:0] r, er; logic [15:0] id; int lat; bit to, st;
    model_write(TX, 8'd1, 2, 32'h1234_5678, 4'hF, er);
    do_write(TX, 16'h0101, 8'd1, 2, 32'h1234_5678, 4'hF, 0, r, id, lat, to, st);
    checks++;
    if (to || r !== 2'b10 || fifo_level_o !== 4'd0) begin
      errors++; $display("FAIL len_err: resp=%b lvl=%0d required 10 0", r, fifo_level_o);
    end
    model_write(TX, 8'd0, 1, 32'h5555_AAAA, 4'h3, er);
    do_write(TX, 16'h0202, 8'd0, 1, 32'h5555_AAAA, 4'h3, 0, r, id, lat, to, st);
    checks++;
    if (to || r !== er || fifo_level_o !== 4'(q.size())) begin
      errors++; $display("FAIL strb: resp=%b lvl=%0d required %b %0d", r, fifo_level_o, er, q.size());
    end
    while (q.size() > 0) begin
      out_ready = 1; @(negedge iclk); out_ready = 0; void'(q.pop_front());
    end
  endtask

  task automatic test_random;
    logic [1:0] r, er; logic [15:0] id, rid; int lat, nb, hold; bit to, st;
    logic [31:0] addr, d; logic [7:0] len; logic [3:0] strb;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: addr = TX;
        2:    addr = SPI;
        default: addr = $urandom & 32'h0000_FFFC;
      endcase
      len  = ($urandom_range(0, 4) == 0) ? 8'd1 : 8'd0;
      nb   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : int'(len) + 1;
      strb = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      d    = $urandom; id = 16'($urandom); hold = $urandom_range(0, 2);
      if (addr == TX && q.size() == 8) begin
        out_ready = 1; @(negedge iclk); out_ready = 0; void'(q.pop_front());
      end
      model_write(addr, len, nb, d, strb, er);
      do_write(addr, id, len, nb, d, strb, hold, r, rid, lat, to, st);
      checks++;
      if (to || r !== er || rid !== id || !st) begin
        errors++;
        $display("FAIL rand_b[%0d]: resp=%b id=%h to=%0d stable=%0d required %b %h 0 1", n, r, rid, to, st, er, id);
      end
      checks++;
      if (ram_addr_o !== m_ram || fifo_level_o !== 4'(q.size())) begin
        errors++;
        $display("FAIL rand_state[%0d]: ram=%h lvl=%0d required %h %0d", n, ram_addr_o, fifo_level_o, m_ram, q.size());
      end
      repeat ($urandom_range(0, 2)) begin
        if (q.size() > 0) begin
          checks++;
          if (!out_valid_o || {out_addr_o, out_data_o} !== q[0]) begin
            errors++; $display("FAIL rand_pop: got %h required %h", {out_addr_o, out_data_o}, q[0]);
          end
          out_ready = 1; @(negedge iclk); out_ready = 0; void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int w;
    @(negedge iclk); aw_valid = 1; aw_addr = TX; aw_id = 16'h0A0A; aw_len = 0;
    @(negedge iclk); aw_valid = 0;
    w_valid = 1; w_data = 32'hCAFE_F00D; w_strb = 4'hF; w_last = 1;
    w = 0;
    while (!w_ready_o && w < TMO) begin @(negedge iclk); w++; end
    @(negedge iclk); w_valid = 0; w_last = 0;
    checks++;
    if (b_valid_o !== 1'b1 || out_valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_resp: b_vld=%b ovld=%b required 1 1", b_valid_o, out_valid_o);
    end
    rst = 1; @(negedge iclk); rst = 0;
    q.delete(); m_ram = '0;
    checks++;
    if (b_valid_o !== 1'b0 || aw_ready_o !== 1'b1 || out_valid_o !== 1'b0 ||
        fifo_level_o !== 4'd0 || ram_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: b_vld=%b aw_rdy=%b ovld=%b lvl=%0d ram=%h required 0 1 0 0 0",
               b_valid_o, aw_ready_o, out_valid_o, fifo_level_o, ram_addr_o);
    end
    b_ready = 1; @(negedge iclk); b_ready = 0;
    checks++;
    if (b_valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_no_b: b_vld=%b required 0", b_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_spiadr();
    test_fifo_push();
    test_fifo_full();
    test_bad_addr();
    test_len_err();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
